// File: rtl/lag_measure_ctrl.sv
// lag_measure_ctrl
//   Measures display lag using an external 5-digit BCD tick counter.
//   A start request first clears the counter. The controller then waits for a
//   frame sync and lights the stimulus pattern. While it waits for light, it
//   ticks the counter once every TICK_DIV clocks. The measurement ends when the
//   photo sensor rises or when the count reaches TIMEOUT_BCD. After a short
//   settle time the counter value is latched and reported.
//
// Ports
//   clock, reset_n    system clock; asynchronous active-low reset
//   start             1-cycle request, ignored while busy
//   abort             level, returns to IDLE from any state, no result
//   frame_sync        1-cycle stimulus boundary pulse, used only in ARMED
//   sensor_in         asynchronous photo sensor level (1 = light)
//   bcdcount[19:0]    counter read-back {d4..d0}
//   counter_trigger   registered tick pulse to the counter
//   counter_reset     registered clear to the counter
//   stimulus_on       drives the displayed test pattern
//   busy              1 in every state except IDLE
//   result[19:0]      last latched BCD count
//   result_valid      1-cycle pulse when result/timeout update
//   timeout           1 = last result ended by timeout

module lag_measure_ctrl #(
  parameter int unsigned TICK_DIV    = 2700,
  parameter logic [19:0] TIMEOUT_BCD = 20'h99999,
  parameter int unsigned SETTLE      = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        frame_sync,
  input  logic        sensor_in,
  input  logic [19:0] bcdcount,
  output logic        counter_trigger,
  output logic        counter_reset,
  output logic        stimulus_on,
  output logic        busy,
  output logic [19:0] result,
  output logic        result_valid,
  output logic        timeout
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(SETTLE + 2);
  localparam logic [PW-1:0] PRE_LAST    = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] SETTLE_LAST = DW'(SETTLE - 1);
  localparam logic [DW-1:0] CLEAR_LAST  = DW'(1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ARMED,
    MEASURE,
    LATCH
  } state_t;

  state_t state, state_d;

  logic [PW-1:0] prescaler, prescaler_d;
  logic [DW-1:0] dwell, dwell_d;
  logic          tmo, tmo_d;
  logic [19:0]   result_d;
  logic          timeout_d;
  logic          result_valid_d;
  logic          trigger_d;

  // [0],[1]: synchroniser; [2]: previous synced level for edge detection
  logic [2:0] sens_sync;
  logic       sens_rise;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sens_sync <= '0;
    end else begin
      sens_sync <= {sens_sync[1:0], sensor_in};
    end
  end

  assign sens_rise = sens_sync[1] & ~sens_sync[2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d        = state;
    prescaler_d    = prescaler;
    dwell_d        = dwell;
    tmo_d          = tmo;
    result_d       = result;
    timeout_d      = timeout;
    result_valid_d = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          dwell_d = '0;
        end
      end
      CLEAR: begin
        if (dwell == CLEAR_LAST) begin
          state_d = ARMED;
        end else begin
          dwell_d = dwell + DW'(1);
        end
      end
      ARMED: begin
        if (frame_sync) begin
          state_d     = MEASURE;
          prescaler_d = '0;
        end
      end
      MEASURE: begin
        prescaler_d = (prescaler == PRE_LAST) ? '0 : prescaler + PW'(1);
        // The sensor is checked before the timeout, so it wins a tie.
        // The timeout compare is skipped while a trigger pulse is high,
        // because the counter is still updating during that pulse.
        if (sens_rise) begin
          state_d = LATCH;
          tmo_d   = 1'b0;
          dwell_d = '0;
        end else if (!counter_trigger && (bcdcount == TIMEOUT_BCD)) begin
          state_d = LATCH;
          tmo_d   = 1'b1;
          dwell_d = '0;
        end
      end
      LATCH: begin
        if (dwell == SETTLE_LAST) begin
          state_d        = IDLE;
          result_d       = bcdcount;
          timeout_d      = tmo;
          result_valid_d = 1'b1;
        end else begin
          dwell_d = dwell + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d        = IDLE;
      result_d       = result;
      timeout_d      = timeout;
      result_valid_d = 1'b0;
    end

    // A tick is issued only while the FSM stays in MEASURE. Leaving MEASURE
    // (sensor edge, timeout or abort) therefore suppresses any further tick.
    trigger_d = (state == MEASURE) && (state_d == MEASURE) && (prescaler == PRE_LAST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler       <= '0;
      dwell           <= '0;
      tmo             <= 1'b0;
      counter_trigger <= 1'b0;
      counter_reset   <= 1'b1;
      stimulus_on     <= 1'b0;
      busy            <= 1'b0;
      result          <= '0;
      result_valid    <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      prescaler       <= prescaler_d;
      dwell           <= dwell_d;
      tmo             <= tmo_d;
      counter_trigger <= trigger_d;
      counter_reset   <= (state_d == CLEAR);
      stimulus_on     <= (state_d == MEASURE);
      busy            <= (state_d != IDLE);
      result          <= result_d;
      result_valid    <= result_valid_d;
      timeout         <= timeout_d;
    end
  end

endmodule
